// File: rtl/llr_load_ctrl_if.sv
// ----------------------------------------------------------------------------
// llr_load_ctrl_if
//   LLR input stream from the demapper into llr_load_ctrl.
//   One soft-bit LLR per accepted beat (in_valid & in_ready).
//
// Signals
//   in_valid  master -> slave  beat valid
//   in_sof    master -> slave  first LLR of a codeword (qualified by in_valid)
//   in_llr    master -> slave  signed LLR, IN_WID bits
//   in_ready  slave -> master  slave can accept a beat this cycle
// ----------------------------------------------------------------------------
interface llr_load_ctrl_if #(
    parameter int IN_WID = 8
);
    logic              in_valid;
    logic              in_sof;
    logic [IN_WID-1:0] in_llr;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_sof,
        output in_llr,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_sof,
        input  in_llr,
        output in_ready
    );
endinterface : llr_load_ctrl_if

// File: rtl/llr_load_ctrl.sv
// ----------------------------------------------------------------------------
// llr_load_ctrl
//   Front-end of the LDPC LLR load path. Takes one LLR per beat, saturates it
//   symmetrically to D_WID bits and spreads one N_CELL*DEPTH codeword
//   round-robin over N_CELL vtc cells: sample k -> cell k mod N_CELL at word
//   k / N_CELL. One register stage between an accepted beat and its strobe.
//
// Ports
//   clk           clock, rising edge
//   reset_n       asynchronous reset, active low
//   load_start    pulse from decoder FSM: open a codeword load (ignored in LOAD)
//   code_rate_in  0 = rate 1/2, 1 = rate 3/4; sampled with load_start
//   s_in          LLR input stream (slave side of llr_load_ctrl_if)
//   sync_out      one-hot write strobe, bit i -> sync_in of cell i
//   data_out      saturated LLR broadcast to every cell's data_in
//   code_rate     rate latched for the current load
//   load_busy     high while in LOAD
//   load_done     pulse with the final strobe of the codeword
//   sof_err       pulse: in_sof arrived mid-codeword
//   sat_cnt       (LLR_SAT_STAT_EN only) saturated counted beats, sticky at max
//
// Configuration
//   LLR_SAT_STAT_EN  when defined, adds sat_cnt and its counter.
// ----------------------------------------------------------------------------
module llr_load_ctrl #(
    parameter int IN_WID = 8,
    parameter int D_WID  = 6,
    parameter int A_WID  = 8,
    parameter int N_CELL = 36,
    parameter int C_WID  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic              code_rate_in,
    llr_load_ctrl_if.slave    s_in,
    output logic [N_CELL-1:0] sync_out,
    output logic [D_WID-1:0]  data_out,
    output logic              code_rate,
    output logic              load_busy,
    output logic              load_done,
    output logic              sof_err
`ifdef LLR_SAT_STAT_EN
    ,
    output logic [15:0]       sat_cnt
`endif
);

    localparam int DEPTH   = 2 ** A_WID;
    localparam int SAT_MAX = 2 ** (D_WID - 1) - 1;

    localparam logic [C_WID-1:0] LAST_CELL = C_WID'(N_CELL - 1);
    localparam logic [A_WID-1:0] LAST_WORD = A_WID'(DEPTH - 1);

    localparam logic signed [IN_WID-1:0] POS_LIM = IN_WID'(SAT_MAX);
    localparam logic signed [IN_WID-1:0] NEG_LIM = -POS_LIM;

    typedef enum logic {
        ST_IDLE,
        ST_LOAD
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [C_WID-1:0]  r_cell_idx;
    logic [A_WID-1:0]  r_word_idx;
    logic              r_sof_seen;
    logic              r_code_rate;
    logic [N_CELL-1:0] r_sync_out;
    logic [D_WID-1:0]  r_data_out;
    logic              r_load_done;
    logic              r_sof_err;

    logic              w_start;
    logic              w_accept;
    logic              w_count;
    logic              w_last;
    logic              w_sof_err;
    logic [C_WID-1:0]  w_cur_cell;
    logic [A_WID-1:0]  w_cur_word;
    logic signed [IN_WID-1:0] w_llr_s;
    logic              w_pos_sat;
    logic              w_neg_sat;
    logic              w_sat;
    logic [D_WID-1:0]  w_llr_sat;

    // ------------------------------------------------------------------
    // Handshake and beat qualification
    // ------------------------------------------------------------------
    assign s_in.in_ready = (r_state == ST_LOAD);
    assign load_busy     = (r_state == ST_LOAD);

    // A load only opens from IDLE; a load_start during LOAD is dropped.
    assign w_start  = (r_state == ST_IDLE) & load_start;
    assign w_accept = s_in.in_valid & s_in.in_ready;
    // Beats before the first SOF of a load are swallowed without effect.
    assign w_count  = w_accept & (s_in.in_sof | r_sof_seen);

    // An SOF beat is always sample 0, regardless of where the counters are.
    assign w_cur_cell = s_in.in_sof ? '0 : r_cell_idx;
    assign w_cur_word = s_in.in_sof ? '0 : r_word_idx;

    assign w_last    = w_count & (w_cur_cell == LAST_CELL) & (w_cur_word == LAST_WORD);
    assign w_sof_err = w_accept & s_in.in_sof & ((r_cell_idx != '0) | (r_word_idx != '0));

    // ------------------------------------------------------------------
    // Symmetric saturation: -2**(D_WID-1) is never produced
    // ------------------------------------------------------------------
    assign w_llr_s   = $signed(s_in.in_llr);
    assign w_pos_sat = (w_llr_s > POS_LIM);
    assign w_neg_sat = (w_llr_s < NEG_LIM);
    assign w_sat     = w_pos_sat | w_neg_sat;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_llr_sat = w_llr_s[D_WID-1:0];
        if (w_pos_sat) begin
            w_llr_sat = D_WID'(SAT_MAX);
        end else if (w_neg_sat) begin
            w_llr_sat = D_WID'(-SAT_MAX);
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: reset is asynchronous and active low; it abandons any partial load immediately.
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (load_start) w_state_nxt = ST_LOAD;
            ST_LOAD: if (w_last)     w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sample counters, SOF tracking and latched code rate
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cell_idx  <= '0;
            r_word_idx  <= '0;
            r_sof_seen  <= 1'b0;
            r_code_rate <= 1'b0;
        end else if (w_start) begin
            r_cell_idx  <= '0;
            r_word_idx  <= '0;
            r_sof_seen  <= 1'b0;
            r_code_rate <= code_rate_in;
        end else if (w_count) begin
            r_sof_seen <= 1'b1;
            if (w_cur_cell == LAST_CELL) begin
                r_cell_idx <= '0;
                // Wraps to 0 after the last word, leaving counters clean.
                r_word_idx <= w_cur_word + A_WID'(1);
            end else begin
                r_cell_idx <= w_cur_cell + C_WID'(1);
                r_word_idx <= w_cur_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_out  <= '0;
            r_data_out  <= '0;
            r_load_done <= 1'b0;
            r_sof_err   <= 1'b0;
        end else begin
            r_sync_out  <= w_count ? (N_CELL'(1) << w_cur_cell) : '0;
            // data_out is a shared bus; it holds between strobes.
            if (w_count) begin
                r_data_out <= w_llr_sat;
            end
            r_load_done <= w_last;
            r_sof_err   <= w_sof_err;
        end
    end

    assign sync_out  = r_sync_out;
    assign data_out  = r_data_out;
    assign code_rate = r_code_rate;
    assign load_done = r_load_done;
    assign sof_err   = r_sof_err;

`ifdef LLR_SAT_STAT_EN
    // ------------------------------------------------------------------
    // Saturation statistics: cleared on an accepted load_start, sticky at max
    // ------------------------------------------------------------------
    logic [15:0] r_sat_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sat_cnt <= '0;
        end else if (w_start) begin
            r_sat_cnt <= '0;
        end else if (w_count & w_sat & (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign sat_cnt = r_sat_cnt;
`endif

endmodule : llr_load_ctrl
